router13_grant_scheduler: RTL and testbench
===========================================

Name: router13_grant_scheduler

Overview:
- Clocked grant controller for the three output merges of a 3-port tree router: parent output (Pout), child-1 output (C1out) and child-2 output (C2out).
- Each output merge has two candidate sources. This block arbitrates between them with round-robin priority.
- A grant is held per packet: it stays up until the tail flit is reported or a hold timeout fires.
- It drives the per-output 2-way merge select (the P/C1/C2 grant) and reports busy and timeout status.

Parameters:
- MAX_HOLD, 64: max cycles one grant may be held. 0 disables the timeout.
- GAP_CYCLES, 1: idle cycles forced between release and the next grant on the same output. 0 is legal.
- HW, $clog2(MAX_HOLD+1): hold-counter width. Derived; do not override.

Ports:
- CLK  input  1  clock; all state on rising edge.
- _RESET  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable. Low blocks new grants only; held grants continue.
- req_p  input  2  requests for Pout. bit0 = C1 source, bit1 = C2 source.
- req_c1  input  2  requests for C1out. bit0 = C2 source, bit1 = P source.
- req_c2  input  2  requests for C2out. bit0 = C1 source, bit1 = P source.
- done_p / done_c1 / done_c2  input  1 each  single-cycle pulse: tail flit accepted on that output.
- clr_timeout  input  1  synchronous clear of all timeout flags.
- gnt_p / gnt_c1 / gnt_c2  output  2 each  one-hot merge select, or 2'b00 when no grant.
- busy  output  3  {c2,c1,p}: output is in HOLD.
- timeout  output  3  {c2,c1,p}: sticky flag, hold limit reached.

Behaviour:
- Reset (asynchronous, _RESET=0):
  - all FSMs to IDLE; gnt_* = 00; busy = 000; timeout = 000; hold counters = 0; gap counters = 0.
  - last-served register = 1 for each output, so input 0 wins the first tie.
- Three identical, independent per-output channels. No cross-output coupling.
- All outputs are registered. No combinational path from any input to gnt/busy/timeout.
- Per-output FSM states: IDLE, HOLD, GAP.
- IDLE:
  - If en=1 and req != 00, pick a winner and go to HOLD. gnt becomes one-hot(winner) on the next edge, i.e. 1-cycle latency from request sample.
  - Winner when one bit is set: that input.
  - Winner when both bits are set: the input not equal to last-served.
  - done is ignored in IDLE.
- HOLD:
  - gnt is held constant; busy=1; hold counter increments each cycle starting from 0.
  - Request deassertion or en=0 does not release the grant.
  - done=1: release. last-served := winner. Go to GAP if GAP_CYCLES>0, else IDLE. gnt=00 from the next cycle.
  - Timeout (MAX_HOLD>0): counter reaches MAX_HOLD-1 with done=0. Set timeout flag, release exactly as on done, last-served := winner.
  - done and timeout in the same cycle: treat as done; flag not set.
- GAP:
  - gnt=00. Count GAP_CYCLES cycles, then go to IDLE.
  - Requests are not sampled during GAP.
  - With GAP_CYCLES=0, HOLD goes straight to IDLE. The earliest next grant is then 2 cycles after done (one cycle with gnt=00).
- Timeout flags:
  - Cleared only by reset or clr_timeout.
  - clr_timeout and a new timeout in the same cycle: flag stays set (set wins).
- Reset mid-HOLD: grant drops immediately (asynchronous). No done is required afterwards.
- Invariant: each gnt_* is never 2'b11.

Test Plan:
- Reset, then req_p=01 at cycle 0 → gnt_p=01 at cycle 1, busy[0]=1. done_p at cycle 5 → gnt_p=00 at cycle 6, then GAP_CYCLES=1 idle cycle.
- req_c1=11 held, done_c1 every 4th cycle of each hold → grants alternate 01,10,01,10. The first grant is 01.
- req_c2=01 granted, then req_c2 drops to 00 while done_c2 is withheld → gnt_c2 stays 01 until done_c2 or timeout.
- MAX_HOLD=8, grant with no done → gnt drops after 8 held cycles, timeout[the output]=1 and stays set. clr_timeout → 0.
- en=0 with req_p=11 → gnt_p stays 00. en=1 → grant next cycle. en=0 mid-HOLD → grant held until done.
- All three outputs driven together with random req/done, _RESET pulsed during HOLD → outputs independent, gnt never 11, all outputs return to reset values at once.

Source files
------------

// File: rtl/router13_grant_scheduler.sv
// Grant scheduler for the three 2-way output merges of a 3-port tree router.
// Each output runs an independent round-robin IDLE/HOLD/GAP channel with registered outputs.

module router13_grant_channel #(
    parameter int MAX_HOLD   = 64,
    parameter int GAP_CYCLES = 1,
    parameter int HW         = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       clr_timeout,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = (HW > 0) ? HW : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] hold_cnt_r, hold_cnt_s;
    logic [GW-1:0] gap_cnt_r, gap_cnt_s;
    logic          last_r, last_s;
    logic [1:0]    gnt_r, gnt_s;
    logic          busy_r, busy_s;
    logic          timeout_r, timeout_s;
    logic          win_s;
    logic          expired_s;

    // Next-state and next-output decode for one merge channel.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        last_s     = last_r;
        gnt_s      = gnt_r;
        timeout_s  = timeout_r & ~clr_timeout;
        // On a tie the input that was not served last wins.
        win_s      = (req == 2'b11) ? ~last_r : req[1];
        expired_s  = (MAX_HOLD > 0) && (hold_cnt_r == HOLD_LAST);

        case (state_r)
            ST_IDLE: begin
                gnt_s = 2'b00;
                if (en && (req != 2'b00)) begin
                    state_s    = ST_HOLD;
                    gnt_s      = win_s ? 2'b10 : 2'b01;
                    hold_cnt_s = {CW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (done || expired_s) begin
                    // done has priority, so a same-cycle expiry never flags.
                    if (!done) begin
                        timeout_s = 1'b1;
                    end else begin
                        timeout_s = timeout_r & ~clr_timeout;
                    end
                    last_s     = gnt_r[1];
                    gnt_s      = 2'b00;
                    hold_cnt_s = {CW{1'b0}};
                    gap_cnt_s  = {GW{1'b0}};
                    state_s    = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    hold_cnt_s = hold_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP: begin
                gnt_s = 2'b00;
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s = {GW{1'b0}};
                    state_s   = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 2'b00;
            end
        endcase

        busy_s = (state_s == ST_HOLD);
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {CW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            last_r     <= 1'b1;
            gnt_r      <= 2'b00;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            last_r     <= last_s;
            gnt_r      <= gnt_s;
            busy_r     <= busy_s;
            timeout_r  <= timeout_s;
        end
    end

    assign gnt     = gnt_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

module router13_grant_scheduler #(
    parameter int MAX_HOLD   = 64,
    parameter int GAP_CYCLES = 1,
    parameter int HW         = $clog2(MAX_HOLD + 1)
) (
    input  logic       CLK,
    input  logic       _RESET,
    input  logic       en,
    input  logic [1:0] req_p,
    input  logic [1:0] req_c1,
    input  logic [1:0] req_c2,
    input  logic       done_p,
    input  logic       done_c1,
    input  logic       done_c2,
    input  logic       clr_timeout,
    output logic [1:0] gnt_p,
    output logic [1:0] gnt_c1,
    output logic [1:0] gnt_c2,
    output logic [2:0] busy,
    output logic [2:0] timeout
);

    router13_grant_channel #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES), .HW(HW)) u_ch_p (
        .clk(CLK), .rst_n(_RESET), .en(en), .req(req_p), .done(done_p),
        .clr_timeout(clr_timeout), .gnt(gnt_p), .busy(busy[0]), .timeout(timeout[0])
    );

    router13_grant_channel #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES), .HW(HW)) u_ch_c1 (
        .clk(CLK), .rst_n(_RESET), .en(en), .req(req_c1), .done(done_c1),
        .clr_timeout(clr_timeout), .gnt(gnt_c1), .busy(busy[1]), .timeout(timeout[1])
    );

    router13_grant_channel #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES), .HW(HW)) u_ch_c2 (
        .clk(CLK), .rst_n(_RESET), .en(en), .req(req_c2), .done(done_c2),
        .clr_timeout(clr_timeout), .gnt(gnt_c2), .busy(busy[2]), .timeout(timeout[2])
    );

endmodule

// File: tb/tb_router13_grant_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level reference model of the three grant channels.

module tb_router13_grant_scheduler;

    localparam int MAX_HOLD   = 8;
    localparam int GAP_CYCLES = 1;

    logic       CLK = 1'b0;
    logic       _RESET;
    logic       en;
    logic [1:0] req_p, req_c1, req_c2;
    logic       done_p, done_c1, done_c2;
    logic       clr_timeout;
    logic [1:0] gnt_p, gnt_c1, gnt_c2;
    logic [2:0] busy, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner = granted input (-1 none), held = cycles held so far
    // including the current one, gap_left = forced idle cycles still to run.
    int owner[3];
    int held[3];
    int gap_left[3];
    int last[3];
    bit tflag[3];

    router13_grant_scheduler #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES)) dut (
        .CLK(CLK), ._RESET(_RESET), .en(en),
        .req_p(req_p), .req_c1(req_c1), .req_c2(req_c2),
        .done_p(done_p), .done_c1(done_c1), .done_c2(done_c2),
        .clr_timeout(clr_timeout),
        .gnt_p(gnt_p), .gnt_c1(gnt_c1), .gnt_c2(gnt_c2),
        .busy(busy), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            owner[c] = -1; held[c] = 0; gap_left[c] = 0; last[c] = 1; tflag[c] = 1'b0;
        end
    endtask

    function automatic logic [7:0] exp_gnt(input int c);
        if (owner[c] < 0) return 8'h00;
        return (owner[c] == 0) ? 8'h01 : 8'h02;
    endfunction

    task automatic model_step();
        logic [1:0] rq[3];
        logic       dn[3];
        rq[0] = req_p;  rq[1] = req_c1; rq[2] = req_c2;
        dn[0] = done_p; dn[1] = done_c1; dn[2] = done_c2;
        for (int c = 0; c < 3; c++) begin
            bit set_t;
            set_t = 1'b0;
            if (owner[c] >= 0) begin
                if (dn[c] || held[c] == MAX_HOLD) begin
                    set_t = !dn[c];
                    last[c] = owner[c];
                    owner[c] = -1;
                    gap_left[c] = GAP_CYCLES;
                end else begin
                    held[c]++;
                end
            end else if (gap_left[c] > 0) begin
                gap_left[c]--;
            end else if (en && rq[c] != 2'b00) begin
                if (rq[c] == 2'b11) owner[c] = 1 - last[c];
                else owner[c] = (rq[c] == 2'b01) ? 0 : 1;
                held[c] = 1;
            end
            tflag[c] = set_t || (tflag[c] && !clr_timeout);
        end
    endtask

    task automatic check_all();
        chk("gnt_p", {6'b0, gnt_p}, exp_gnt(0));
        chk("gnt_c1", {6'b0, gnt_c1}, exp_gnt(1));
        chk("gnt_c2", {6'b0, gnt_c2}, exp_gnt(2));
        chk("busy", {5'b0, busy}, {5'b0, owner[2] >= 0, owner[1] >= 0, owner[0] >= 0});
        chk("timeout", {5'b0, timeout}, {5'b0, tflag[2], tflag[1], tflag[0]});
        chk("gnt_not_11", {5'b0, gnt_c2 == 2'b11, gnt_c1 == 2'b11, gnt_p == 2'b11}, 8'h00);
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic reset_pulse();
        #2;
        _RESET = 1'b0;
        #1;
        chk("rst_gnt", {2'b0, gnt_c2, gnt_c1, gnt_p}, 8'h00);
        chk("rst_busy", {5'b0, busy}, 8'h00);
        chk("rst_timeout", {5'b0, timeout}, 8'h00);
        model_reset();
        @(posedge CLK);
        #1;
        _RESET = 1'b1;
    endtask

    initial begin
        int k;
        logic [1:0] prev;
        bit hit;

        _RESET = 1'b0; en = 1'b1; clr_timeout = 1'b0;
        req_p = 2'b00; req_c1 = 2'b00; req_c2 = 2'b00;
        done_p = 1'b0; done_c1 = 1'b0; done_c2 = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        _RESET = 1'b1;
        step();

        // Single request, release by done, then the forced gap.
        req_p = 2'b01;
        step();
        chk("t1_grant", {6'b0, gnt_p}, 8'h01);
        chk("t1_busy", {7'b0, busy[0]}, 8'h01);
        req_p = 2'b00;
        repeat (4) step();
        done_p = 1'b1;
        step();
        done_p = 1'b0;
        chk("t1_release", {6'b0, gnt_p}, 8'h00);
        repeat (3) step();

        // Persistent tie on C1 alternates between the two sources.
        req_c1 = 2'b11; k = 0; prev = 2'b00;
        for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
            done_c1 = (owner[1] >= 0) && (held[1] == 4);
            step();
            if (prev == 2'b00 && gnt_c1 != 2'b00) begin
                chk("t2_alternate", {6'b0, gnt_c1}, (k % 2 == 1) ? 8'h02 : 8'h01);
                k++;
            end
            prev = gnt_c1;
        end
        chk("t2_grants", 8'(k), 8'd4);
        req_c1 = 2'b00;
        for (int i = 0; i < 10 && owner[1] >= 0; i++) begin
            done_c1 = (held[1] == 4);
            step();
        end
        done_c1 = 1'b0;
        repeat (3) step();

        // Dropping the request does not release the grant.
        req_c2 = 2'b01;
        step();
        req_c2 = 2'b00;
        repeat (5) step();
        chk("t3_held", {6'b0, gnt_c2}, 8'h01);
        done_c2 = 1'b1;
        step();
        done_c2 = 1'b0;
        repeat (3) step();

        // Hold timeout on P, sticky flag, then clear.
        req_p = 2'b10;
        step();
        req_p = 2'b00;
        repeat (7) step();
        chk("t4_last_held", {6'b0, gnt_p}, 8'h02);
        step();
        chk("t4_dropped", {6'b0, gnt_p}, 8'h00);
        repeat (3) step();
        chk("t4_sticky", {7'b0, timeout[0]}, 8'h01);
        clr_timeout = 1'b1;
        step();
        clr_timeout = 1'b0;
        chk("t4_cleared", {7'b0, timeout[0]}, 8'h00);

        // Enable gates new grants but not held ones.
        en = 1'b0; req_p = 2'b11;
        repeat (3) begin
            step();
            chk("t5_blocked", {6'b0, gnt_p}, 8'h00);
        end
        en = 1'b1;
        step();
        chk("t5_grant", {6'b0, gnt_p}, 8'h01);
        en = 1'b0; req_p = 2'b00;
        repeat (3) step();
        chk("t5_held", {6'b0, gnt_p}, 8'h01);
        done_p = 1'b1;
        step();
        done_p = 1'b0; en = 1'b1;
        repeat (3) step();

        // Random traffic on all outputs with a reset pulse during a hold.
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_p  = 2'($urandom_range(0, 3));
            req_c1 = 2'($urandom_range(0, 3));
            req_c2 = 2'($urandom_range(0, 3));
            done_p  = ($urandom_range(0, 3) == 0);
            done_c1 = ($urandom_range(0, 3) == 0);
            done_c2 = ($urandom_range(0, 3) == 0);
            en          = ($urandom_range(0, 9) != 0);
            clr_timeout = ($urandom_range(0, 19) == 0);
            step();
            if (cyc == 200) begin
                hit = 1'b0;
                for (int w = 0; w < 50 && !hit; w++) begin
                    if (owner[0] >= 0) hit = 1'b1;
                    else step();
                end
                chk("rand_hold_seen", {7'b0, hit}, 8'h01);
                reset_pulse();
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
